rf_wr_arbiter: RTL

Shares the register file's single write port between the in-order pipeline writeback and a long-latency multiply/divide unit (MDU). It keeps a 32-entry scoreboard of registers that have an MDU write outstanding, and raises a decode stall on RAW/WAW hazards against those registers. It also raises a stall when an MDU result has been starved too long. The block sits between the WB stage, the MDU and the register file write port.

---
 rtl/rf_wr_arbiter_pkg.sv | 22 ++
 rtl/rf_scoreboard.sv | 44 ++++
 rtl/rf_wr_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rf_wr_arbiter_pkg.sv
// ============================================================================
// rf_wr_arbiter_pkg : shared constants and types for the RF write arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package rf_wr_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_BUF  = 2'd2,
    GNT_BYP  = 2'd3
  } grant_e;

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// rf_scoreboard : pending-MDU-write vector with set/clear and 3 read ports
// Revision: 1.0
// ============================================================================
`default_nettype none

module rf_scoreboard
  import rf_wr_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en_i,
  input  logic [REG_AW-1:0] set_idx_i,
  input  logic              clr_en_i,
  input  logic [REG_AW-1:0] clr_idx_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic              hazard_o,
  output logic [NREG-1:0]   pending_o
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Set is applied after clear so a fresh issue supersedes a retiring result.
  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) pending_d[clr_idx_i] = 1'b0;
    if (set_en_i) pending_d[set_idx_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign hazard_o  = pending_q[rs1_i] | pending_q[rs2_i] | pending_q[rd_i];
  assign pending_o = pending_q;

endmodule

`default_nettype wire

// File: rtl/rf_wr_arbiter.sv
// ============================================================================
// rf_wr_arbiter : shares the RF write port between WB and the MDU
// Revision: 1.0
// ============================================================================
`default_nettype none

module rf_wr_arbiter
  import rf_wr_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wr,
  input  logic [REG_AW-1:0] pipe_rd,
  input  logic [XLEN-1:0]   pipe_wd,
  input  logic              mdu_valid,
  input  logic [REG_AW-1:0] mdu_rd,
  input  logic [XLEN-1:0]   mdu_wd,
  output logic              mdu_ready,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  output logic              stall,
  output logic              rf_wr,
  output logic [REG_AW-1:0] rf_wr_adr,
  output logic [XLEN-1:0]   rf_wr_dt,
  output logic [NREG-1:0]   pending
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic              buf_v_q,   buf_v_d;
  logic [REG_AW-1:0] buf_rd_q,  buf_rd_d;
  logic [XLEN-1:0]   buf_wd_q,  buf_wd_d;
  logic [WAIT_W-1:0] starve_q,  starve_d;
  logic              rf_wr_q,   rf_wr_d;
  logic [REG_AW-1:0] rf_adr_q,  rf_adr_d;
  logic [XLEN-1:0]   rf_dt_q,   rf_dt_d;

  logic   pipe_req;
  logic   mdu_take;
  logic   hazard;
  grant_e gnt;

  assign mdu_ready = ~buf_v_q;
  assign pipe_req  = pipe_wr & (pipe_rd != '0);
  // An x0 MDU result is still handshaked but never occupies the buffer.
  assign mdu_take  = mdu_valid & ~buf_v_q & (mdu_rd != '0);

  always_comb begin
    gnt = GNT_NONE;
    if (pipe_req)     gnt = GNT_PIPE;
    else if (buf_v_q) gnt = GNT_BUF;
    else if (mdu_take) gnt = GNT_BYP;
  end

  always_comb begin
    buf_v_d  = buf_v_q;
    buf_rd_d = buf_rd_q;
    buf_wd_d = buf_wd_q;
    starve_d = starve_q;
    rf_wr_d  = 1'b0;
    rf_adr_d = rf_adr_q;
    rf_dt_d  = rf_dt_q;

    if (buf_v_q && gnt != GNT_BUF) begin
      if (starve_q < MAX_WAIT_C) starve_d = starve_q + 1'b1;
    end else begin
      starve_d = '0;
    end

    if (gnt == GNT_BUF) buf_v_d = 1'b0;
    if (mdu_take && gnt == GNT_PIPE) begin
      buf_v_d  = 1'b1;
      buf_rd_d = mdu_rd;
      buf_wd_d = mdu_wd;
    end

    unique case (gnt)
      GNT_PIPE: begin
        rf_wr_d  = 1'b1;
        rf_adr_d = pipe_rd;
        rf_dt_d  = pipe_wd;
      end
      GNT_BUF: begin
        rf_wr_d  = 1'b1;
        rf_adr_d = buf_rd_q;
        rf_dt_d  = buf_wd_q;
      end
      GNT_BYP: begin
        rf_wr_d  = 1'b1;
        rf_adr_d = mdu_rd;
        rf_dt_d  = mdu_wd;
      end
      default: rf_wr_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_v_q  <= 1'b0;
      buf_rd_q <= '0;
      buf_wd_q <= '0;
      starve_q <= '0;
      rf_wr_q  <= 1'b0;
      rf_adr_q <= '0;
      rf_dt_q  <= '0;
    end else begin
      buf_v_q  <= buf_v_d;
      buf_rd_q <= buf_rd_d;
      buf_wd_q <= buf_wd_d;
      starve_q <= starve_d;
      rf_wr_q  <= rf_wr_d;
      rf_adr_q <= rf_adr_d;
      rf_dt_q  <= rf_dt_d;
    end
  end

  rf_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en_i  (issue_valid),
    .set_idx_i (issue_rd),
    .clr_en_i  ((gnt == GNT_BUF) || (gnt == GNT_BYP)),
    .clr_idx_i ((gnt == GNT_BUF) ? buf_rd_q : mdu_rd),
    .rs1_i     (dec_rs1),
    .rs2_i     (dec_rs2),
    .rd_i      (dec_rd),
    .hazard_o  (hazard),
    .pending_o (pending)
  );

  assign stall     = hazard | (starve_q >= MAX_WAIT_C);
  assign rf_wr     = rf_wr_q;
  assign rf_wr_adr = rf_adr_q;
  assign rf_wr_dt  = rf_dt_q;

endmodule

`default_nettype wire
